// File: rtl/dp_issue_ctrl.sv
// ============================================================================
//  Module   : dp_issue_ctrl
//  Purpose  : Issue/commit controller for ARM data-processing instructions.
//             Accepts a decoded instruction, evaluates its condition against
//             the stored NZCV flags, drives the ALU, waits ALU_LAT cycles and
//             commits the register writeback and flag update.
//  Options  : FLAG_LOAD_EN - adds an MSR-style flag write (flag_ld,
//             flag_ld_val), honoured only while idle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_issue_ctrl #(
  parameter int ALU_LAT = 1,   // ALU settling cycles, legal 1..15
  parameter int REG_AW  = 4    // register-file address width
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef FLAG_LOAD_EN
  input  logic              flag_ld,
  input  logic [3:0]        flag_ld_val,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_opcode,
  input  logic              in_s,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [31:0]       in_rn_val,
  input  logic [31:0]       in_shift_op,
  input  logic              in_shift_c,
  output logic [3:0]        fn,
  output logic [31:0]       left_op,
  output logic [31:0]       right_op,
  output logic              cin,
  input  logic [31:0]       alu_output,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic [3:0]        flags,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [3:0] c_alu_lat = 4'(ALU_LAT);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [3:0]          r_cond;
  logic [3:0]          r_opcode;
  logic                r_s;
  logic [REG_AW-1:0]   r_rd;
  logic [31:0]         r_rn_val;
  logic [31:0]         r_shift_op;
  logic                r_shift_c;

  logic w_n, w_z, w_c, w_v;
  logic w_cond_pass;
  logic w_is_cmp;
  logic w_is_arith;
  logic w_is_sub;
  logic w_set_flags;

  assign w_n = flags[3];
  assign w_z = flags[2];
  assign w_c = flags[1];
  assign w_v = flags[0];

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

  // Condition-field evaluation against the currently stored flags
  always_comb begin
    w_cond_pass = 1'b0;
    case (r_cond)
      4'h0:    w_cond_pass = w_z;
      4'h1:    w_cond_pass = ~w_z;
      4'h2:    w_cond_pass = w_c;
      4'h3:    w_cond_pass = ~w_c;
      4'h4:    w_cond_pass = w_n;
      4'h5:    w_cond_pass = ~w_n;
      4'h6:    w_cond_pass = w_v;
      4'h7:    w_cond_pass = ~w_v;
      4'h8:    w_cond_pass = w_c & ~w_z;
      4'h9:    w_cond_pass = ~w_c | w_z;
      4'hA:    w_cond_pass = (w_n == w_v);
      4'hB:    w_cond_pass = (w_n != w_v);
      4'hC:    w_cond_pass = ~w_z & (w_n == w_v);
      4'hD:    w_cond_pass = w_z | (w_n != w_v);
      4'hE:    w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  // Opcode classification: compares never write back; the subtract class
  // reports borrow from the ALU, which ARM stores inverted as carry
  always_comb begin
    w_is_cmp    = (r_opcode[3:2] == 2'b10);
    w_is_arith  = (r_opcode inside {[4'h2:4'h7], 4'hA, 4'hB});
    w_is_sub    = (r_opcode inside {4'h2, 4'h3, 4'h6, 4'h7, 4'hA});
    w_set_flags = r_s | w_is_cmp;
  end

  // Issue/commit state machine with registered ALU drive, writeback and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_cond     <= 4'd0;
      r_opcode   <= 4'd0;
      r_s        <= 1'b0;
      r_rd       <= '0;
      r_rn_val   <= 32'd0;
      r_shift_op <= 32'd0;
      r_shift_c  <= 1'b0;
      fn         <= 4'd0;
      left_op    <= 32'd0;
      right_op   <= 32'd0;
      cin        <= 1'b0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= 32'd0;
      flags      <= 4'd0;
    end else begin
      wb_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef FLAG_LOAD_EN
          if (flag_ld) begin
            flags <= flag_ld_val;
          end
`endif
          if (in_valid) begin
            r_cond     <= in_cond;
            r_opcode   <= in_opcode;
            r_s        <= in_s;
            r_rd       <= in_rd;
            r_rn_val   <= in_rn_val;
            r_shift_op <= in_shift_op;
            r_shift_c  <= in_shift_c;
            r_state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (w_cond_pass) begin
            fn       <= r_opcode;
            left_op  <= r_rn_val;
            right_op <= r_shift_op;
            cin      <= w_c;
            r_cnt    <= c_alu_lat;
            r_state  <= S_WAIT;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // The ALU result has been stable for ALU_LAT cycles on the last
          // WAIT edge, so the writeback is captured there and the strobe is
          // high for exactly the COMMIT cycle.
          if (r_cnt == 4'd1) begin
            r_state <= S_COMMIT;
            if (!w_is_cmp) begin
              wb_en   <= 1'b1;
              wb_addr <= r_rd;
              wb_data <= alu_output;
            end
          end
        end
        S_COMMIT: begin
          if (w_set_flags) begin
            flags[3] <= alu_n;
            flags[2] <= alu_z;
            if (w_is_arith) begin
              flags[1] <= w_is_sub ? ~alu_c : alu_c;
              flags[0] <= alu_v;
            end else begin
              flags[1] <= r_shift_c;
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dp_issue_ctrl.sv
// ============================================================================
//  Module   : tb_dp_issue_ctrl
//  Purpose  : Self-checking bench for dp_issue_ctrl: directed scenarios plus
//             randomized instructions against an ARM-semantics model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dp_issue_ctrl;

  localparam int ALU_LAT = 1;
  localparam int REG_AW  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cond;
  logic [3:0]        in_opcode;
  logic              in_s;
  logic [REG_AW-1:0] in_rd;
  logic [31:0]       in_rn_val;
  logic [31:0]       in_shift_op;
  logic              in_shift_c;
  logic [3:0]        fn;
  logic [31:0]       left_op;
  logic [31:0]       right_op;
  logic              cin;
  logic [31:0]       alu_output;
  logic              alu_n, alu_z, alu_c, alu_v;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [31:0]       wb_data;
  logic [3:0]        flags;
  logic              busy;
`ifdef FLAG_LOAD_EN
  logic              flag_ld;
  logic [3:0]        flag_ld_val;
  assign flag_ld     = 1'b0;
  assign flag_ld_val = 4'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] m_flags;

  dp_issue_ctrl #(.ALU_LAT(ALU_LAT), .REG_AW(REG_AW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef FLAG_LOAD_EN
    .flag_ld    (flag_ld),
    .flag_ld_val(flag_ld_val),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cond    (in_cond),
    .in_opcode  (in_opcode),
    .in_s       (in_s),
    .in_rd      (in_rd),
    .in_rn_val  (in_rn_val),
    .in_shift_op(in_shift_op),
    .in_shift_c (in_shift_c),
    .fn         (fn),
    .left_op    (left_op),
    .right_op   (right_op),
    .cin        (cin),
    .alu_output (alu_output),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flags      (flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: subtractions report borrow on alu_c
  always_comb begin
    logic [32:0] t;
    logic [31:0] a, b;
    a = left_op;
    b = right_op;
    t = 33'd0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (fn)
      4'h0, 4'h8: t = {1'b0, a & b};
      4'h1, 4'h9: t = {1'b0, a ^ b};
      4'h2, 4'hA: t = {1'b0, a} - {1'b0, b};
      4'h3:       t = {1'b0, b} - {1'b0, a};
      4'h4, 4'hB: t = {1'b0, a} + {1'b0, b};
      4'h5:       t = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      4'h6:       t = {1'b0, a} - {1'b0, b} - {32'd0, ~cin};
      4'h7:       t = {1'b0, b} - {1'b0, a} - {32'd0, ~cin};
      4'hC:       t = {1'b0, a | b};
      4'hD:       t = {1'b0, b};
      4'hE:       t = {1'b0, a & ~b};
      default:    t = {1'b0, ~b};
    endcase
    case (fn)
      4'h2, 4'hA, 4'h6: begin alu_c = t[32]; alu_v = (a[31] != b[31]) && (t[31] != a[31]); end
      4'h3, 4'h7:       begin alu_c = t[32]; alu_v = (b[31] != a[31]) && (t[31] != b[31]); end
      4'h4, 4'hB, 4'h5: begin alu_c = t[32]; alu_v = (a[31] == b[31]) && (t[31] != a[31]); end
      default:          begin alu_c = 1'b0;  alu_v = 1'b0; end
    endcase
    alu_output = t[31:0];
    alu_n = t[31];
    alu_z = (t[31:0] == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ARM condition codes: pairs of (base, inverse), 1110 always, 1111 never
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    base = 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? !base : base;
  endfunction

  // ARM semantics: arithmetic as AddWithCarry(x, y, c), flags from exact sums
  function automatic void model_exec(input logic [3:0] op, input bit s,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input bit shc, inout logic [3:0] f,
                                     output bit wr, output logic [31:0] res);
    logic [31:0] x, y;
    bit cc, arith, cout, ovf;
    longint unsigned u;
    longint sg;
    arith = 1'b1; x = a; y = b; cc = 1'b0; res = 32'd0;
    case (op)
      4'h2, 4'hA: begin x = a;  y = ~b; cc = 1'b1;  end
      4'h3:       begin x = b;  y = ~a; cc = 1'b1;  end
      4'h4, 4'hB: begin x = a;  y = b;  cc = 1'b0;  end
      4'h5:       begin x = a;  y = b;  cc = f[1];  end
      4'h6:       begin x = a;  y = ~b; cc = f[1];  end
      4'h7:       begin x = b;  y = ~a; cc = f[1];  end
      default:    arith = 1'b0;
    endcase
    cout = 1'b0; ovf = 1'b0;
    if (arith) begin
      u    = 64'(x) + 64'(y) + 64'(cc);
      res  = u[31:0];
      cout = u[32];
      sg   = longint'($signed(x)) + longint'($signed(y)) + longint'(cc);
      ovf  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
    end else begin
      case (op)
        4'h0, 4'h8: res = a & b;
        4'h1, 4'h9: res = a ^ b;
        4'hC:       res = a | b;
        4'hD:       res = b;
        4'hE:       res = a & ~b;
        default:    res = ~b;
      endcase
    end
    wr = !(op >= 4'h8 && op <= 4'hB);
    if (s || !wr) begin
      f[3] = res[31];
      f[2] = (res == 32'd0);
      f[1] = arith ? cout : shc;
      if (arith) f[0] = ovf;
    end
  endfunction

  task automatic garbage();
    in_valid    = 1'($urandom);
    in_cond     = 4'($urandom);
    in_opcode   = 4'($urandom);
    in_s        = 1'($urandom);
    in_rd       = REG_AW'($urandom);
    in_rn_val   = $urandom;
    in_shift_op = $urandom;
    in_shift_c  = 1'($urandom);
  endtask

  // Issue one instruction (called just after a negedge with in_ready high)
  task automatic issue(input logic [3:0] cond, input logic [3:0] op, input bit s,
                       input logic [REG_AW-1:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input bit shc);
    bit pass, wr, done;
    logic [31:0] res;
    logic [3:0] f_before;
    int lat, wb_cnt, wb_cyc;
    logic [REG_AW-1:0] got_addr;
    logic [31:0] got_data;
    f_before = m_flags;
    pass = cond_holds(cond, m_flags);
    res = 32'd0; wr = 1'b0;
    if (pass) model_exec(op, s, a, b, shc, m_flags, wr, res);
    in_valid = 1'b1; in_cond = cond; in_opcode = op; in_s = s; in_rd = rd;
    in_rn_val = a; in_shift_op = b; in_shift_c = shc;
    @(posedge clk);
    @(negedge clk);
    done = 1'b0; lat = 0; wb_cnt = 0; wb_cyc = 0; got_addr = '0; got_data = 32'd0;
    for (int n = 1; n <= 40; n++) begin
      if (wb_en) begin
        wb_cnt++; wb_cyc = n; got_addr = wb_addr; got_data = wb_data;
      end
      if (pass && n == 2) begin
        chk("fn", 32'(fn), 32'(op));
        chk("left_op", left_op, a);
        chk("right_op", right_op, b);
        chk("cin", 32'(cin), 32'(f_before[1]));
      end
      if (in_ready) begin
        done = 1'b1; lat = n;
        break;
      end
      garbage();
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("latency", lat, pass ? ALU_LAT + 3 : 2);
    chk("wb_count", wb_cnt, (pass && wr) ? 1 : 0);
    if (pass && wr) begin
      chk("wb_cycle", wb_cyc, ALU_LAT + 2);
      chk("wb_addr", 32'(got_addr), 32'(rd));
      chk("wb_data", got_data, res);
    end
    chk("flags", 32'(flags), 32'(m_flags));
    chk("busy", 32'(busy), 32'(!in_ready));
  endtask

  function automatic logic [31:0] pick_val();
    logic [31:0] vals [4];
    vals[0] = 32'h0000_0000; vals[1] = 32'h7FFF_FFFF;
    vals[2] = 32'h8000_0000; vals[3] = 32'hFFFF_FFFF;
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 3));
      1: return vals[$urandom_range(0, 3)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit saw_wb;
    rst_n = 1'b0; m_flags = 4'd0;
    in_valid = 1'b0; in_cond = 4'd0; in_opcode = 4'd0; in_s = 1'b0; in_rd = '0;
    in_rn_val = 32'd0; in_shift_op = 32'd0; in_shift_c = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_fn", 32'(fn), 32'd0);
    chk("rst_left_op", left_op, 32'd0);
    chk("rst_right_op", right_op, 32'd0);
    chk("rst_cin", 32'(cin), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    issue(4'hE, 4'h4, 1'b1, 4'd3, 32'h7FFF_FFFF, 32'd1, 1'b0);   // ADDS
    chk("adds_flags", 32'(flags), 32'h9);
    issue(4'h0, 4'hD, 1'b0, 4'd5, 32'd0, 32'h1234, 1'b0);        // MOVEQ fails
    issue(4'hE, 4'hA, 1'b0, 4'd1, 32'd5, 32'd5, 1'b0);           // CMP
    chk("cmp_flags", 32'(flags), 32'h6);
    issue(4'hE, 4'h5, 1'b0, 4'd2, 32'd1, 32'd1, 1'b0);           // ADC with C=1
    issue(4'hE, 4'h4, 1'b1, 4'd3, 32'h7FFF_FFFF, 32'd1, 1'b0);   // ADDS sets V
    issue(4'hE, 4'h0, 1'b1, 4'd4, 32'hF0, 32'h0F, 1'b1);         // ANDS
    chk("ands_flags", 32'(flags), 32'h7);

    // Reset while an ADD is in WAIT
    in_valid = 1'b1; in_cond = 4'hE; in_opcode = 4'h4; in_s = 1'b1; in_rd = 4'd7;
    in_rn_val = 32'd10; in_shift_op = 32'd20;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    saw_wb = wb_en;
    repeat (2) begin @(negedge clk); saw_wb |= wb_en; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); saw_wb |= wb_en; end
    chk("mid_rst_no_wb", 32'(saw_wb), 32'd0);
    m_flags = 4'd0;
    chk("post_rst_flags", 32'(flags), 32'd0);

    // Randomized instructions
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(4'($urandom), 4'($urandom), 1'($urandom), REG_AW'($urandom),
            pick_val(), pick_val(), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dp_issue_ctrl.md
Name: dp_issue_ctrl

Overview:
- Issue/commit controller for ARM data-processing instructions; it is the initiator side of the team ALU interface.
- Accepts a decoded instruction over a valid/ready handshake and evaluates its condition field against the stored NZCV flags.
- For a passing instruction: drives FN/LEFT_OP/RIGHT_OP/CIN, waits the ALU latency, then commits register writeback and flag updates.
- Sits between the decode stage and the ALU/register file.

Parameters:
- ALU_LAT, 1: cycles the ALU needs for a stable result; legal range 1..15.
- REG_AW, 4: register-file address width.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  instruction valid.
- IN_READY  out  1  controller can accept an instruction.
- IN_COND  in  4  ARM condition field.
- IN_OPCODE  in  4  ALU function code (ARM data-processing encoding).
- IN_S  in  1  set-flags bit.
- IN_RD  in  REG_AW  destination register.
- IN_RN_VAL  in  32  first-operand value.
- IN_SHIFT_OP  in  32  shifter operand.
- IN_SHIFT_C  in  1  shifter carry-out.
- FN  out  4  to ALU.
- LEFT_OP  out  32  to ALU.
- RIGHT_OP  out  32  to ALU.
- CIN  out  1  to ALU.
- ALU_OUTPUT  in  32  ALU result.
- ALU_N, ALU_Z, ALU_C, ALU_V  in  1 each  ALU flag outputs.
- WB_EN  out  1  one-cycle writeback strobe.
- WB_ADDR  out  REG_AW  writeback address.
- WB_DATA  out  32  writeback data.
- FLAGS  out  4  stored {N,Z,C,V}.
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, RST_N=0): state=IDLE, FLAGS=0, FN/LEFT_OP/RIGHT_OP/CIN=0, WB_EN=0, WB_ADDR=0, WB_DATA=0, wait counter=0. IN_READY=1 and BUSY=0 while in reset.
- IN_READY = (state==IDLE), decoded from state.
- IDLE: when IN_VALID=1, latch all IN_* fields and go to EVAL.
- EVAL: evaluate the condition on the current FLAGS:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 = never.
  - Fail: go to IDLE; no writeback; flags unchanged.
  - Pass: register FN=opcode, LEFT_OP=Rn, RIGHT_OP=shift_op, CIN=FLAGS.C; load counter=ALU_LAT; go to WAIT.
- WAIT: ALU outputs are held stable. Counter decrements each cycle; on reaching 0, go to COMMIT. WAIT lasts exactly ALU_LAT cycles.
- COMMIT (1 cycle): sample ALU_*.
  - Writeback: WB_EN=1 with WB_ADDR=Rd and WB_DATA=ALU_OUTPUT, unless opcode is 1000–1011 (TST/TEQ/CMP/CMN, which never write back).
  - Flag update when IN_S=1 or opcode is 1000–1011:
    - N and Z are taken from the ALU.
    - Arithmetic ops (0010–0111, 1010, 1011): V=ALU_V. C=~ALU_C for the subtract class (SUB, RSB, SBC, RSC, CMP; ARM C = not-borrow), otherwise C=ALU_C.
    - Logical ops (0000, 0001, 1000, 1001, 1100–1111): C=IN_SHIFT_C; V unchanged.
  - The new FLAGS are visible the cycle after COMMIT. Then go to IDLE.
- WB_EN is low in every state except COMMIT. WB_ADDR/WB_DATA hold their last value otherwise.
- Timing: a passing instruction occupies ALU_LAT+3 cycles from acceptance to IN_READY high again; a failing one occupies 2 cycles.
- The next instruction's EVAL always sees the flags committed by the previous instruction; no hazard exists.
- IN_VALID while not ready is ignored; the producer holds the instruction.
- Reset mid-operation: the in-flight instruction is dropped, no WB_EN, FLAGS cleared.

Optional Feature:
- Macro: FLAG_LOAD_EN.
- Defined: adds ports FLAG_LD (in 1) and FLAG_LD_VAL (in 4), an MSR-style flag write.
  - The load is honoured only in IDLE and FLAGS takes FLAG_LD_VAL on that edge.
  - If IN_VALID is also high in the same cycle, both take effect; the accepted instruction's EVAL sees the loaded flags.
  - FLAG_LD outside IDLE is ignored.
- Undefined: the ports do not exist and FLAGS change only in COMMIT.

Test Plan:
- The bench connects a combinational ALU model; ALU_LAT=1.
- ADDS (op 0100, cond 1110, S=1), Rn=0x7FFFFFFF, op2=1 -> WB_EN with WB_DATA=0x80000000, FLAGS=1001 (N=1, V=1); IN_READY high 4 cycles after acceptance.
- CMP (1010), Rn=5, op2=5 -> no WB_EN; FLAGS Z=1, C=1 (ALU_C=0 inverted), N=0, V=0.
- FLAGS Z=0, MOVEQ (cond 0000) -> no WB_EN, FLAGS unchanged, IN_READY returns after 2 cycles.
- FLAGS C=1, ADC (0101) with 1 and 1 -> CIN=1 during WAIT, WB_DATA=3.
- FLAGS V=1, ANDS (0000) with 0xF0 & 0x0F and IN_SHIFT_C=1 -> WB_DATA=0, FLAGS Z=1, C=1, V=1 (retained).
- RST_N low during WAIT of an ADD -> no WB_EN ever, FLAGS=0000, IN_READY=1 immediately.
